// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle between the RV32i pipeline and the branch predictor.
// The pipeline is the master and drives lookup, hazard and resolution inputs.
interface branch_predictor_if;
   logic [31:0] PC_F;
   logic        Stall_En;
   logic        Flush_D;
   logic        Flush_E;
   logic        Branch_E;
   logic        Branch_Taken_E;
   logic [31:0] PC_E;
   logic [31:0] Target_E;
   logic        Predict_Taken_F;
   logic [31:0] Predict_Target_F;
   logic        Predict_Taken_E;

   modport master (
      output PC_F, Stall_En, Flush_D, Flush_E,
      output Branch_E, Branch_Taken_E, PC_E, Target_E,
      input  Predict_Taken_F, Predict_Target_F, Predict_Taken_E
   );

   modport slave (
      input  PC_F, Stall_En, Flush_D, Flush_E,
      input  Branch_E, Branch_Taken_E, PC_E, Target_E,
      output Predict_Taken_F, Predict_Target_F, Predict_Taken_E
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, trained from Execute resolution,
// plus the Decode/Execute prediction pipeline feeding the hazard unit.
module branch_predictor #(
   parameter int ENTRIES = 64,
   parameter int INDEX_W = $clog2(ENTRIES)
) (
   input logic               CLK,
   input logic               RST,
   branch_predictor_if.slave bp
);
   localparam int TAG_W = 32 - INDEX_W - 2;

   function automatic logic [1:0] ctr_inc(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_dec(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];

   logic [INDEX_W-1:0] idx_f, idx_e;
   logic [TAG_W-1:0]   tag_f, tag_e;
   logic               hit_f, hit_e;
   logic               train_e, alloc_e, tgt_we;
   logic               pred_d_p1, pred_e_p2;
   logic               unused_pc_lsbs;

   assign idx_f = bp.PC_F[INDEX_W+1:2];
   assign tag_f = bp.PC_F[31:INDEX_W+2];
   assign idx_e = bp.PC_E[INDEX_W+1:2];
   assign tag_e = bp.PC_E[31:INDEX_W+2];
   assign unused_pc_lsbs = &{1'b0, bp.PC_F[1:0], bp.PC_E[1:0]};

   // Fetch stage: combinational lookup, reads pre-update state (no bypass)
   assign hit_f               = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign bp.Predict_Taken_F  = hit_f && ctr_q[idx_f][1];
   assign bp.Predict_Target_F = target_q[idx_f];

   // Execute-stage training; Flush_E does not gate it because it kills the
   // instruction entering Execute, not the one resolving now
   assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
   assign train_e = !RST && bp.Branch_E && hit_e;
   assign alloc_e = !RST && bp.Branch_E && !hit_e && bp.Branch_Taken_E;
   assign tgt_we  = !RST && bp.Branch_E && bp.Branch_Taken_E;

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
      end else if (train_e) begin
         ctr_q[idx_e] <= bp.Branch_Taken_E ? ctr_inc(ctr_q[idx_e]) : ctr_dec(ctr_q[idx_e]);
      end else if (alloc_e) begin
         valid_q[idx_e] <= 1'b1;
         ctr_q[idx_e]   <= 2'b10;
      end
   end

   // Tag and target storage carry no reset; a valid bit guards their use
   always_ff @(posedge CLK) begin
      if (tgt_we) begin
         target_q[idx_e] <= bp.Target_E;
         tag_q[idx_e]    <= tag_e;
      end
   end

   // F -> D -> E prediction pipeline; flush wins over stall
   always_ff @(posedge CLK) begin
      if (RST) begin
         pred_d_p1 <= 1'b0;
         pred_e_p2 <= 1'b0;
      end else begin
         if (bp.Flush_D)       pred_d_p1 <= 1'b0;
         else if (!bp.Stall_En) pred_d_p1 <= bp.Predict_Taken_F;
         pred_e_p2 <= bp.Flush_E ? 1'b0 : pred_d_p1;
      end
   end

   assign bp.Predict_Taken_E = pred_e_p2;
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// checked against a word-address-keyed behavioural BTB model.
module tb_branch_predictor;
   localparam int ENTRIES = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_predictor_if bif ();

   branch_predictor #(.ENTRIES(ENTRIES)) dut (
      .CLK(clk),
      .RST(rst),
      .bp (bif)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: each slot remembers the full word address it holds
   bit          m_valid [ENTRIES];
   int unsigned m_word  [ENTRIES];
   int unsigned m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   int          m_pd, m_pe;

   logic        obs_tf, obs_te;
   logic [31:0] obs_tgt;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int slot(input int unsigned pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic bit m_hit(input int unsigned pc);
      return m_valid[slot(pc)] && (m_word[slot(pc)] == (pc >> 2));
   endfunction

   function automatic bit m_taken(input int unsigned pc);
      return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      m_pd = 0;
      m_pe = 0;
   endtask

   // One clock: drive, check at the falling edge, then advance the model on the rising edge
   task automatic cycle(input bit r, input int unsigned pcf, input bit st, input bit fd,
                        input bit fe, input bit b, input bit bt,
                        input int unsigned pce, input int unsigned tge);
      bit exp_tf;
      int s;
      rst                = r;
      bif.PC_F           = pcf;
      bif.Stall_En       = st;
      bif.Flush_D        = fd;
      bif.Flush_E        = fe;
      bif.Branch_E       = b;
      bif.Branch_Taken_E = bt;
      bif.PC_E           = pce;
      bif.Target_E       = tge;
      @(negedge clk);
      exp_tf  = m_taken(pcf);
      obs_tf  = bif.Predict_Taken_F;
      obs_te  = bif.Predict_Taken_E;
      obs_tgt = bif.Predict_Target_F;
      check_eq("taken_f", {31'b0, obs_tf}, {31'b0, exp_tf});
      check_eq("taken_e", {31'b0, obs_te}, m_pe);
      if (m_valid[slot(pcf)]) check_eq("target_f", obs_tgt, m_tgt[slot(pcf)]);
      @(posedge clk);
      if (r) begin
         model_reset();
      end else begin
         m_pe = fe ? 0 : m_pd;
         if (fd)       m_pd = 0;
         else if (!st) m_pd = exp_tf;
         if (b) begin
            s = slot(pce);
            if (m_hit(pce)) begin
               m_ctr[s] = bt ? ((m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1)
                             : ((m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1);
               if (bt) m_tgt[s] = tge;
            end else if (bt) begin
               m_valid[s] = 1'b1;
               m_word[s]  = pce >> 2;
               m_tgt[s]   = tge;
               m_ctr[s]   = 2;
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int unsigned pcf);
      cycle(0, pcf, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic resolve(input int unsigned pc, input bit bt, input int unsigned tgt);
      cycle(0, 32'h0, 0, 0, 0, 1, bt, pc, tgt);
   endtask

   task automatic do_reset();
      cycle(1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      bif.PC_F = '0; bif.Stall_En = 0; bif.Flush_D = 0; bif.Flush_E = 0;
      bif.Branch_E = 0; bif.Branch_Taken_E = 0; bif.PC_E = '0; bif.Target_E = '0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // Post-reset sweep
      for (int unsigned pc = 0; pc <= 32'hFC; pc += 4) idle(pc);
      check_eq("rst_taken_e", {31'b0, obs_te}, 32'h0);

      // Cold allocation and its not-taken control
      resolve(32'h40, 1, 32'h10);
      idle(32'h40);
      check_eq("alloc_taken", {31'b0, obs_tf}, 32'h1);
      check_eq("alloc_target", obs_tgt, 32'h10);
      do_reset();
      resolve(32'h40, 0, 32'h10);
      idle(32'h40);
      check_eq("nt_no_alloc", {31'b0, obs_tf}, 32'h0);

      // Hysteresis and saturation
      do_reset();
      resolve(32'h40, 1, 32'h10);
      repeat (3) resolve(32'h40, 1, 32'h10);
      resolve(32'h40, 0, 32'h10);
      idle(32'h40);
      check_eq("hyst_one_nt", {31'b0, obs_tf}, 32'h1);
      resolve(32'h40, 0, 32'h10);
      idle(32'h40);
      check_eq("hyst_two_nt", {31'b0, obs_tf}, 32'h0);
      repeat (3) resolve(32'h40, 0, 32'h10);
      resolve(32'h40, 1, 32'h10);
      idle(32'h40);
      check_eq("sat_low", {31'b0, obs_tf}, 32'h0);
      resolve(32'h40, 1, 32'h10);
      idle(32'h40);
      check_eq("recover", {31'b0, obs_tf}, 32'h1);

      // Aliasing
      resolve(32'h140, 1, 32'h200);
      idle(32'h40);
      check_eq("alias_evict", {31'b0, obs_tf}, 32'h0);
      idle(32'h140);
      check_eq("alias_hit", {31'b0, obs_tf}, 32'h1);
      check_eq("alias_target", obs_tgt, 32'h200);

      // Load-use bubble: stall two cycles with Flush_E
      idle(32'h140);
      cycle(0, 32'h0, 1, 0, 1, 0, 0, 0, 0);
      cycle(0, 32'h0, 1, 0, 1, 0, 0, 0, 0);
      check_eq("stall_e0", {31'b0, obs_te}, 32'h0);
      idle(32'h0);
      check_eq("stall_e1", {31'b0, obs_te}, 32'h0);
      idle(32'h0);
      check_eq("release_e", {31'b0, obs_te}, 32'h1);

      // Flush_D has priority over Stall_En
      idle(32'h140);
      cycle(0, 32'h0, 1, 1, 0, 0, 0, 0, 0);
      idle(32'h0);
      check_eq("pre_flush_e", {31'b0, obs_te}, 32'h1);
      idle(32'h0);
      check_eq("flush_d_pri", {31'b0, obs_te}, 32'h0);

      // Same-cycle lookup and update read the old entry
      do_reset();
      cycle(0, 32'h80, 0, 0, 0, 1, 1, 32'h80, 32'h300);
      check_eq("same_cyc_old", {31'b0, obs_tf}, 32'h0);
      idle(32'h80);
      check_eq("same_cyc_new", {31'b0, obs_tf}, 32'h1);

      // Update presented in the reset cycle is dropped
      cycle(1, 32'h0, 0, 0, 0, 1, 1, 32'h40, 32'h10);
      idle(32'h40);
      check_eq("rst_drop", {31'b0, obs_tf}, 32'h0);

      // Randomized traffic over a small aliasing PC set
      for (int n = 0; n < 3000; n++) begin
         int unsigned pcf, pce;
         bit r, st, fd, fe, b, bt;
         pcf = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8) | $urandom_range(0, 3);
         pce = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 1) << 8);
         r   = ($urandom_range(0, 199) == 0);
         st  = ($urandom_range(0, 4) == 0);
         fd  = ($urandom_range(0, 6) == 0);
         fe  = ($urandom_range(0, 5) == 0);
         b   = ($urandom_range(0, 1) == 1);
         bt  = ($urandom_range(0, 2) != 0);
         cycle(r, pcf, st, fd, fe, b, bt, pce, $urandom & 32'hFFFF_FFFC);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
